// File: rtl/cache_request_servicer_pkg.sv
// Shared definitions for the cache request servicer: command opcodes and FSM state encodings.
package cache_request_servicer_pkg;

    localparam logic [1:0] CMD_WORD_READ   = 2'b00;
    localparam logic [1:0] CMD_WORD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_BLOCK_READ  = 2'b10;
    localparam logic [1:0] CMD_BLOCK_WRITE = 2'b11;

    // Bit index of the uncached flag for the default 3-bit command; it only travels to the response.
    localparam int CMD_UNCACHED = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_RESPOND   = 2'd3
    } state_e;

endpackage

// File: rtl/cache_request_servicer.sv
// Pops one cache request at a time, runs it as word beats on the memory bus and
// returns a single response per command, with read beats assembled into a line.
module cache_request_servicer
    import cache_request_servicer_pkg::*;
#(
    parameter int BW_COMMAND = 3,
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 128,
    parameter int BW_WORD    = 32
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  empty_i,
    input  logic [BW_COMMAND-1:0] command_i,
    input  logic [BW_ADDR-1:0]    addr_i,
    input  logic [BW_DATA-1:0]    data_i,
    output logic                  read_o,
    output logic                  mem_req_o,
    output logic                  mem_wren_o,
    output logic [BW_ADDR-1:0]    mem_addr_o,
    output logic [BW_WORD-1:0]    mem_data_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_valid_i,
    input  logic [BW_WORD-1:0]    mem_data_i,
    output logic                  resp_valid_o,
    output logic [BW_COMMAND-1:0] resp_command_o,
    output logic [BW_ADDR-1:0]    resp_addr_o,
    output logic [BW_DATA-1:0]    resp_data_o,
    input  logic                  resp_ready_i
);

    localparam int N_WORDS = BW_DATA / BW_WORD;
    localparam int BW_BEAT = $clog2(N_WORDS);

    state_e                state;
    logic [BW_COMMAND-1:0] cmd_q;
    logic [BW_ADDR-1:0]    addr_q;
    logic [BW_DATA-1:0]    data_q;
    logic [BW_DATA-1:0]    line_q;
    logic [BW_BEAT-1:0]    beat;

    logic is_block;
    logic is_write;
    logic last_beat;

    assign is_block  = cmd_q[1];
    assign is_write  = cmd_q[0];
    assign last_beat = !is_block || (beat == BW_BEAT'(N_WORDS - 1));

    // The pop strobe is gated by reset so every output reads 0 while reset is held.
    assign read_o     = resetn_i && (state == ST_IDLE) && !empty_i;
    assign mem_req_o  = (state == ST_ISSUE);
    assign mem_wren_o = (state == ST_ISSUE) && is_write;
    // Block beats walk the aligned line; the low bits are replaced, so the address never carries out.
    assign mem_addr_o = is_block ? {addr_q[BW_ADDR-1:BW_BEAT], beat} : addr_q;
    assign mem_data_o = data_q[int'(beat) * BW_WORD +: BW_WORD];

    assign resp_valid_o   = (state == ST_RESPOND);
    assign resp_command_o = cmd_q;
    assign resp_addr_o    = addr_q;
    assign resp_data_o    = is_write ? '0 : line_q;

    // NOTE: state and every captured register use non-blocking assignments so all of them
    // update together from the values sampled at the same clock edge.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            // NOTE: the wide capture and line registers are cleared too, so the response
            // outputs read 0 out of reset instead of stale data.
            state  <= ST_IDLE;
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            line_q <= '0;
            beat   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty_i) begin
                        cmd_q  <= command_i;
                        addr_q <= addr_i;
                        data_q <= data_i;
                        line_q <= '0;
                        beat   <= '0;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready_i) begin
                        if (!is_write) begin
                            state <= ST_WAIT_DATA;
                        end else if (last_beat) begin
                            state <= ST_RESPOND;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (mem_valid_i) begin
                        line_q[int'(beat) * BW_WORD +: BW_WORD] <= mem_data_i;
                        if (last_beat) begin
                            state <= ST_RESPOND;
                        end else begin
                            beat  <= beat + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_RESPOND: begin
                    if (resp_ready_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_request_servicer.sv
// Directed, table-driven bench for cache_request_servicer with a small bus responder
// and hand-computed beat addresses, write data, responses and latencies.
module tb_cache_request_servicer;
    import cache_request_servicer_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         empty;
    logic [2:0]   command;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         read_o;
    logic         mem_req;
    logic         mem_wren;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic         mem_valid;
    logic [31:0]  mem_rdata;
    logic         resp_valid;
    logic [2:0]   resp_command;
    logic [31:0]  resp_addr;
    logic [127:0] resp_data;
    logic         resp_ready;

    int total = 0;
    int bad   = 0;

    cache_request_servicer dut (
        .clock_i       (clk),
        .resetn_i      (rst_n),
        .empty_i       (empty),
        .command_i     (command),
        .addr_i        (addr),
        .data_i        (data),
        .read_o        (read_o),
        .mem_req_o     (mem_req),
        .mem_wren_o    (mem_wren),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_ready_i   (mem_ready),
        .mem_valid_i   (mem_valid),
        .mem_data_i    (mem_rdata),
        .resp_valid_o  (resp_valid),
        .resp_command_o(resp_command),
        .resp_addr_o   (resp_addr),
        .resp_data_o   (resp_data),
        .resp_ready_i  (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   cmd;
        logic [31:0]  addr;
        logic [127:0] data;
        int           ready_stall;
        int           resp_stall;
        logic         spurious;
        int           exp_beats;
        logic [31:0]  exp_addr0;
        logic         exp_wren;
        logic [127:0] exp_resp;
        int           exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory contents seen by read beats.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge after the response handshake.
    task automatic run_txn(input vec_t v, input string tag);
        int          cyc;
        int          stall;
        int          rstall;
        int          nb;
        logic        pend;
        logic        done;
        logic [31:0] pend_addr;
        logic [31:0] hold_addr;
        logic [31:0] hold_wdata;
        empty   = 1'b0;
        command = v.cmd;
        addr    = v.addr;
        data    = v.data;
        #1 check({tag, " pop"}, read_o, 1'b1);
        @(negedge clk);
        empty = 1'b1; command = '0; addr = '0; data = '0;
        cyc = 1; stall = 0; rstall = 0; nb = 0; pend = 1'b0; done = 1'b0;
        pend_addr = '0; hold_addr = '0; hold_wdata = '0;
        while (!done && cyc < 200) begin
            mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0; resp_ready = 1'b0; empty = 1'b1;
            if (mem_req) begin
                if (pend) check({tag, " one_outstanding"}, pend, 1'b0);
                if (stall > 0) begin
                    check({tag, " stall_addr"}, mem_addr, hold_addr);
                    if (mem_wren) check({tag, " stall_wdata"}, mem_wdata, hold_wdata);
                end
                if (stall < v.ready_stall) begin
                    if (stall == 0) begin hold_addr = mem_addr; hold_wdata = mem_wdata; end
                    stall++;
                    if (v.spurious) begin mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
                end else begin
                    mem_ready = 1'b1;
                    stall = 0;
                    check($sformatf("%s beat%0d_addr", tag, nb), mem_addr, 32'(v.exp_addr0 + 32'(nb)));
                    check($sformatf("%s beat%0d_wren", tag, nb), mem_wren, v.exp_wren);
                    if (mem_wren) check($sformatf("%s beat%0d_wdata", tag, nb), mem_wdata, v.data[nb*32 +: 32]);
                    else begin pend = 1'b1; pend_addr = mem_addr; end
                    nb++;
                end
            end else if (pend) begin
                mem_valid = 1'b1;
                mem_rdata = rd_word(pend_addr);
                pend = 1'b0;
            end
            if (resp_valid) begin
                if (rstall == 0) check({tag, " latency"}, cyc, v.exp_lat);
                check({tag, " resp_cmd"}, resp_command, v.cmd);
                check({tag, " resp_addr"}, resp_addr, v.addr);
                check({tag, " resp_data"}, resp_data, v.exp_resp);
                if (rstall < v.resp_stall) begin
                    empty = 1'b0; command = 3'b010; addr = 32'h999;
                    #1 check({tag, " no_pop_in_respond"}, read_o, 1'b0);
                    rstall++;
                end else begin
                    resp_ready = 1'b1;
                    done = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " completed"}, done, 1'b1);
        check({tag, " beat_count"}, nb, v.exp_beats);
        resp_ready = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        empty = 1'b1; command = '0; addr = '0;
    endtask

    initial begin
        rst_n = 1'b0; empty = 1'b0; command = 3'b010; addr = 32'h55; data = '1;
        mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;

        //      cmd     addr           data                                     rdy rsp spur beats addr0          wr  resp                                     lat
        vecs[0] = '{3'b000, 32'h100,      '0,                                      0, 0, 1'b0, 1, 32'h100,      1'b0, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF, 3};
        vecs[1] = '{3'b010, 32'h203,      '0,                                      0, 0, 1'b0, 4, 32'h200,      1'b0, 128'hC0DE0203_C0DE0202_C0DE0201_C0DE0200, 9};
        vecs[2] = '{3'b011, 32'h40,       128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 2, 0, 1'b0, 4, 32'h40,       1'b1, '0, 13};
        vecs[3] = '{3'b000, 32'h5,        '0,                                      0, 5, 1'b0, 1, 32'h5,        1'b0, 128'h0000_0000_0000_0000_0000_0000_C0DE_0005, 3};
        vecs[4] = '{3'b101, 32'h77,       128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_12345678, 1, 0, 1'b1, 1, 32'h77,       1'b1, '0, 3};
        vecs[5] = '{3'b110, 32'hFFFFFFFE, '0,                                      0, 0, 1'b0, 4, 32'hFFFFFFFC, 1'b0, 128'hC0DEFFFF_C0DEFFFE_C0DEFFFD_C0DEFFFC, 9};
        vecs[6] = '{3'b000, 32'h37,       '0,                                      1, 0, 1'b1, 1, 32'h37,       1'b0, 128'h0000_0000_0000_0000_0000_0000_C0DE_0037, 4};
        vecs[7] = '{3'b001, 32'h0,        128'h11111111_22222222_33333333_44444444, 0, 0, 1'b0, 1, 32'h0,        1'b1, '0, 2};

        // Reset state, with the buffer non-empty to show the pop strobe stays low in reset.
        #12;
        check("rst read_o", read_o, 1'b0);
        check("rst mem_req", mem_req, 1'b0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst resp_valid", resp_valid, 1'b0);
        check("rst resp_data", resp_data, 128'h0);
        @(negedge clk); empty = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a block read, after beat 1 has been accepted.
        empty = 1'b0; command = CMD_BLOCK_READ; addr = 32'h300;
        @(negedge clk);
        empty = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0BAD_0300;
        @(negedge clk);
        mem_valid = 1'b0; mem_ready = 1'b1;
        check("mid beat1_addr", mem_addr, 32'h301);
        @(negedge clk);
        mem_ready = 1'b0; empty = 1'b0; command = CMD_BLOCK_READ; addr = 32'h304;
        rst_n = 1'b0;
        #1;
        check("arst read_o", read_o, 1'b0);
        check("arst mem_req", mem_req, 1'b0);
        check("arst mem_addr", mem_addr, 32'h0);
        check("arst resp_cmd", resp_command, 3'b000);
        check("arst resp_data", resp_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1; empty = 1'b1;
        @(negedge clk);
        run_txn('{3'b010, 32'h304, '0, 0, 0, 1'b0, 4, 32'h304, 1'b0,
                  128'hC0DE0307_C0DE0306_C0DE0305_C0DE0304, 9}, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
